cmos_decode_v2: RTL and testbench
=================================

Name: cmos_decode_v2

Overview:
Parametrised DVP (parallel camera) capture front-end, successor to the fixed 8-bit/RGB565 decoder. Runs entirely in the sensor pixel clock domain. Samples href/vsync/data, skips start-up frames and packs BYTES_PER_PIX beats into one pixel. Emits a stream with start-of-frame and end-of-line markers to the downstream async FIFO / VDMA bridge, plus per-frame geometry status.

Parameters:
DATA_W, 8, sensor data bus width (8 or 10).
BYTES_PER_PIX, 2, beats per pixel (1..3); pixel width = DATA_W*BYTES_PER_PIX.
FRAME_WAITCNT, 15, number of frames discarded after reset before output starts (0..255).
VSYNC_POL, 1, level of cmos_vsync_i during vertical blanking (1 = high).
CNT_W, 12, width of line/pixel counters.

Ports:
cmos_pclk_i  in  1  sensor pixel clock; only clock.
rst_i  in  1  asynchronous, active-high reset.
cmos_href_i  in  1  line valid, active high.
cmos_vsync_i  in  1  frame sync, polarity per VSYNC_POL.
cmos_data_i  in  DATA_W  sensor data.
capture_en_i  in  1  capture request; sampled only at frame start.
pix_data_o  out  DATA_W*BYTES_PER_PIX  assembled pixel; first beat in MSBs.
pix_valid_o  out  1  pixel qualifier, one cycle per pixel.
pix_sof_o  out  1  with first pixel of frame.
pix_eol_o  out  1  with last pixel of each line.
frame_width_o  out  CNT_W  pixels in first line of last completed frame.
frame_height_o  out  CNT_W  lines in last completed frame.
frame_done_o  out  1  one-cycle pulse when width/height update.
err_o  out  1  one-cycle pulse on partial pixel or mid-line vsync.

Behaviour:
- Reset: all outputs 0. State S_SKIP, skip counter 0, beat counter 0, hold buffer empty.
- Input stage: href, vsync and data are registered once (stage 1). vsync is normalised to "blank" = (vsync==VSYNC_POL). Edges are detected from stage 1 versus stage 2.
- FSM:
  - S_SKIP: count blank-falling edges (frame starts). When count == FRAME_WAITCNT, go to S_VBLANK. If FRAME_WAITCNT == 0, go to S_VBLANK on the first cycle after reset.
  - S_VBLANK: wait for a blank-falling edge. If capture_en_i = 1 at that cycle, go to S_FRAME with sof_pending = 1; otherwise stay. capture_en_i changes mid-frame have no effect.
  - S_FRAME: assemble pixels. A blank-rising edge ends the frame: frame_done_o pulses, width/height register, go to S_VBLANK.
- Pixel assembly:
  - Each stage-1 cycle with href=1 shifts the beat into the accumulator and increments the beat counter.
  - At count BYTES_PER_PIX-1 the pixel completes, the counter wraps to 0, and the pixel goes into a one-entry hold buffer.
- Hold buffer / emit:
  - The held pixel is emitted (pix_valid_o=1, eol=0) in the cycle the next pixel completes.
  - On an href-falling edge the held pixel is emitted with eol=1.
  - pix_sof_o accompanies the first emitted pixel when sof_pending is set, then sof_pending clears.
  - Latency: pin beat to pix_valid_o is 2 cycles for the last pixel of a line. Other pixels are emitted when their successor completes.
- Boundary conditions:
  - href falls with beat counter ≠ 0: partial beats are discarded, err_o pulses, and the held pixel is still emitted with eol=1.
  - href falls with the buffer empty (0-pixel line): no emit, no line count.
  - Blank rises while href=1: held pixel dropped, err_o pulses, line not counted, frame ends normally.
  - Line counter and width counter saturate at 2^CNT_W-1 (no wrap).
  - Skip counter saturates at FRAME_WAITCNT.
- Reset mid-frame: immediate return to S_SKIP. Start-up frames are re-skipped.

Optional Feature:
CMOS_DECODE_LINECHK_EN:
- Defined: every line in the frame is compared to the first-line width. A mismatch pulses err_o at that line's href fall. frame_done_o is suppressed for a frame containing any mismatch, and the status holds its previous values.
- Undefined: no comparison; only the first-line width is recorded.

Decomposition:
- Package cmos_decode_pkg holds the state enum (S_SKIP, S_VBLANK, S_FRAME) and localparam PIX_W = DATA_W*BYTES_PER_PIX helper.
- Sub-module cmos_pix_pack holds the beat counter, accumulator and hold buffer (eol/partial handling). The top level keeps the sync stage, FSM and geometry counters.

Test Plan:
1. FRAME_WAITCNT=2, 3 frames of 4 lines × 8 px, BPP=2 -> no pix_valid_o during frames 1–2; frame 3 yields 32 valids, sof on the first, eol on every 8th, frame_width_o=8, frame_height_o=4, frame_done_o once.
2. BPP=2, line of 7 beats -> 3 pixels emitted, third with eol=1, err_o pulses once at the href fall.
3. capture_en_i low at frame start and raised mid-frame -> zero pixels that frame; capture starts at the next frame with sof.
4. Blank asserted while href=1 after 5 pixels -> 4 pixels emitted, err_o=1, frame_height_o excludes that line.
5. rst_i pulsed mid-line -> all outputs 0 the same cycle; FRAME_WAITCNT frames skipped again.
6. CMOS_DECODE_LINECHK_EN, lines of 8,8,6,8 px -> err_o at line 3, no frame_done_o, status unchanged from the prior frame.

Source files
------------

// File: rtl/cmos_decode_pkg.sv
// Shared types and helpers for the cmos_decode_v2 DVP capture front-end.
package cmos_decode_pkg;

    // Capture FSM states.
    typedef enum logic [1:0] {
        S_SKIP   = 2'd0,
        S_VBLANK = 2'd1,
        S_FRAME  = 2'd2
    } state_e;

    // Assembled pixel width for a given bus width and beat count.
    function automatic int pix_width(input int data_w, input int bytes_per_pix);
        return data_w * bytes_per_pix;
    endfunction

endpackage

// File: rtl/cmos_pix_pack.sv
// Beat-to-pixel packer: beat counter, shift accumulator and a one-entry hold
// buffer. A pixel is released when its successor completes or, tagged as end
// of line, when the line ends. Partial beats at line end are discarded.
// Deasserting en_i clears all state (frame boundaries, abort).
module cmos_pix_pack #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int PIX_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              beat_vld_i,
    input  logic [DATA_W-1:0] beat_data_i,
    input  logic              line_end_i,
    output logic              emit_o,
    output logic [PIX_W-1:0]  emit_data_o,
    output logic              emit_eol_o,
    output logic              partial_o
);

    logic [1:0]       beat_cnt_q, beat_cnt_d;
    logic [PIX_W-1:0] acc_q, acc_d, acc_shift;
    logic [PIX_W-1:0] hold_data_q, hold_data_d;
    logic             hold_vld_q, hold_vld_d;
    logic             pix_done;

    // Shift beats in (first beat ends up in the MSBs) and manage the hold buffer.
    always_comb begin
        acc_shift   = PIX_W'({acc_q, beat_data_i});
        pix_done    = en_i && beat_vld_i && (beat_cnt_q == 2'(BYTES_PER_PIX - 1));
        emit_o      = en_i && hold_vld_q && (pix_done || line_end_i);
        emit_data_o = hold_data_q;
        emit_eol_o  = line_end_i;
        partial_o   = en_i && line_end_i && (beat_cnt_q != 2'd0);

        beat_cnt_d  = beat_cnt_q;
        acc_d       = acc_q;
        hold_data_d = hold_data_q;
        hold_vld_d  = hold_vld_q;

        if (!en_i) begin
            beat_cnt_d = 2'd0;
            acc_d      = '0;
            hold_vld_d = 1'b0;
        end else if (line_end_i) begin
            beat_cnt_d = 2'd0;
            hold_vld_d = 1'b0;
        end else if (beat_vld_i) begin
            acc_d = acc_shift;
            if (pix_done) begin
                beat_cnt_d  = 2'd0;
                hold_vld_d  = 1'b1;
                hold_data_d = acc_shift;
            end else begin
                beat_cnt_d = beat_cnt_q + 2'd1;
            end
        end
    end

    // Packer state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_q  <= 2'd0;
            acc_q       <= '0;
            hold_data_q <= '0;
            hold_vld_q  <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            acc_q       <= acc_d;
            hold_data_q <= hold_data_d;
            hold_vld_q  <= hold_vld_d;
        end
    end

endmodule

// File: rtl/cmos_decode_v2.sv
// DVP capture front-end: input sync stage, skip/vblank/frame FSM, pixel
// stream with sof/eol markers and per-frame geometry status.
// Optional macro CMOS_DECODE_LINECHK_EN: check every line against the first
// line's width; a mismatching frame flags err_o and does not update status.
module cmos_decode_v2 import cmos_decode_pkg::*; #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int FRAME_WAITCNT = 15,
    parameter int VSYNC_POL     = 1,
    parameter int CNT_W         = 12
) (
    input  logic                            cmos_pclk_i,
    input  logic                            rst_i,
    input  logic                            cmos_href_i,
    input  logic                            cmos_vsync_i,
    input  logic [DATA_W-1:0]               cmos_data_i,
    input  logic                            capture_en_i,
    output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data_o,
    output logic                            pix_valid_o,
    output logic                            pix_sof_o,
    output logic                            pix_eol_o,
    output logic [CNT_W-1:0]                frame_width_o,
    output logic [CNT_W-1:0]                frame_height_o,
    output logic                            frame_done_o,
    output logic                            err_o
);

    localparam int PIX_W = pix_width(DATA_W, BYTES_PER_PIX);

    logic              href_s1_q, href_s2_q, blank_s1_q, blank_s2_q;
    logic [DATA_W-1:0] data_s1_q;
    logic              blank_fall, blank_rise, href_fall, frame_end, pack_en;

    state_e            state_q, state_d;
    logic [7:0]        skip_cnt_q, skip_cnt_d;
    logic              sof_pending_q, sof_pending_d;
    logic [CNT_W-1:0]  line_cnt_q, line_cnt_d, width_cnt_q, width_cnt_d, width_inc;
    logic [CNT_W-1:0]  first_width_q, first_width_d;
    logic              first_done_q, first_done_d, mismatch_q, mismatch_d, mismatch_now;
    logic [CNT_W-1:0]  frame_width_q, frame_width_d, frame_height_q, frame_height_d;
    logic              frame_done_q, frame_done_d, err_q, err_d;
    logic              pix_valid_q, pix_valid_d, pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d;
    logic [PIX_W-1:0]  pix_data_q, pix_data_d;

    logic              pack_emit, pack_eol, pack_partial;
    logic [PIX_W-1:0]  pack_data;

    // Two-stage input capture; vsync normalised to "blank".
    always_ff @(posedge cmos_pclk_i or posedge rst_i) begin
        if (rst_i) begin
            href_s1_q  <= 1'b0;
            href_s2_q  <= 1'b0;
            blank_s1_q <= 1'b0;
            blank_s2_q <= 1'b0;
            data_s1_q  <= '0;
        end else begin
            href_s1_q  <= cmos_href_i;
            href_s2_q  <= href_s1_q;
            blank_s1_q <= (cmos_vsync_i == 1'(VSYNC_POL));
            blank_s2_q <= blank_s1_q;
            data_s1_q  <= cmos_data_i;
        end
    end

    // Edge detection and packer enable (cleared in the frame-ending cycle).
    always_comb begin
        blank_fall = blank_s2_q && !blank_s1_q;
        blank_rise = !blank_s2_q && blank_s1_q;
        href_fall  = href_s2_q && !href_s1_q;
        frame_end  = (state_q == S_FRAME) && blank_rise;
        pack_en    = (state_q == S_FRAME) && !blank_rise;
        width_inc  = (width_cnt_q == '1) ? width_cnt_q : width_cnt_q + CNT_W'(1);
`ifdef CMOS_DECODE_LINECHK_EN
        mismatch_now = pack_emit && pack_eol && first_done_q && (width_inc != first_width_q);
`else
        mismatch_now = 1'b0;
`endif
    end

    cmos_pix_pack #(
        .DATA_W       (DATA_W),
        .BYTES_PER_PIX(BYTES_PER_PIX),
        .PIX_W        (PIX_W)
    ) u_pack (
        .clk_i      (cmos_pclk_i),
        .rst_i      (rst_i),
        .en_i       (pack_en),
        .beat_vld_i (href_s1_q),
        .beat_data_i(data_s1_q),
        .line_end_i (href_fall),
        .emit_o     (pack_emit),
        .emit_data_o(pack_data),
        .emit_eol_o (pack_eol),
        .partial_o  (pack_partial)
    );

    // FSM next state, geometry counters and registered output values.
    always_comb begin
        state_d        = state_q;
        skip_cnt_d     = skip_cnt_q;
        sof_pending_d  = sof_pending_q;
        line_cnt_d     = line_cnt_q;
        width_cnt_d    = width_cnt_q;
        first_width_d  = first_width_q;
        first_done_d   = first_done_q;
        mismatch_d     = mismatch_q;
        frame_width_d  = frame_width_q;
        frame_height_d = frame_height_q;
        frame_done_d   = 1'b0;
        err_d          = 1'b0;
        pix_valid_d    = 1'b0;
        pix_data_d     = '0;
        pix_sof_d      = 1'b0;
        pix_eol_d      = 1'b0;

        case (state_q)
            S_SKIP: begin
                if (skip_cnt_q == 8'(FRAME_WAITCNT)) begin
                    state_d = S_VBLANK;
                end else if (blank_fall) begin
                    skip_cnt_d = skip_cnt_q + 8'd1;
                end
            end
            S_VBLANK: begin
                if (blank_fall && capture_en_i) begin
                    state_d       = S_FRAME;
                    sof_pending_d = 1'b1;
                    line_cnt_d    = '0;
                    width_cnt_d   = '0;
                    first_width_d = '0;
                    first_done_d  = 1'b0;
                    mismatch_d    = 1'b0;
                end
            end
            S_FRAME: begin
                if (frame_end) begin
                    state_d       = S_VBLANK;
                    sof_pending_d = 1'b0;
                    err_d         = href_s1_q;
                    if (!mismatch_q) begin
                        frame_done_d   = 1'b1;
                        frame_width_d  = first_width_q;
                        frame_height_d = line_cnt_q;
                    end
                end else begin
                    if (pack_emit) begin
                        pix_valid_d   = 1'b1;
                        pix_data_d    = pack_data;
                        pix_sof_d     = sof_pending_q;
                        pix_eol_d     = pack_eol;
                        sof_pending_d = 1'b0;
                        width_cnt_d   = width_inc;
                    end
                    if (pack_emit && pack_eol) begin
                        width_cnt_d = '0;
                        line_cnt_d  = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + CNT_W'(1);
                        if (!first_done_q) begin
                            first_width_d = width_inc;
                            first_done_d  = 1'b1;
                        end
                    end
                    if (mismatch_now) mismatch_d = 1'b1;
                    if (pack_partial || mismatch_now) err_d = 1'b1;
                end
            end
            default: state_d = S_SKIP;
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge cmos_pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_SKIP;
            skip_cnt_q     <= 8'd0;
            sof_pending_q  <= 1'b0;
            line_cnt_q     <= '0;
            width_cnt_q    <= '0;
            first_width_q  <= '0;
            first_done_q   <= 1'b0;
            mismatch_q     <= 1'b0;
            frame_width_q  <= '0;
            frame_height_q <= '0;
            frame_done_q   <= 1'b0;
            err_q          <= 1'b0;
            pix_valid_q    <= 1'b0;
            pix_data_q     <= '0;
            pix_sof_q      <= 1'b0;
            pix_eol_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            skip_cnt_q     <= skip_cnt_d;
            sof_pending_q  <= sof_pending_d;
            line_cnt_q     <= line_cnt_d;
            width_cnt_q    <= width_cnt_d;
            first_width_q  <= first_width_d;
            first_done_q   <= first_done_d;
            mismatch_q     <= mismatch_d;
            frame_width_q  <= frame_width_d;
            frame_height_q <= frame_height_d;
            frame_done_q   <= frame_done_d;
            err_q          <= err_d;
            pix_valid_q    <= pix_valid_d;
            pix_data_q     <= pix_data_d;
            pix_sof_q      <= pix_sof_d;
            pix_eol_q      <= pix_eol_d;
        end
    end

    assign pix_data_o     = pix_data_q;
    assign pix_valid_o    = pix_valid_q;
    assign pix_sof_o      = pix_sof_q;
    assign pix_eol_o      = pix_eol_q;
    assign frame_width_o  = frame_width_q;
    assign frame_height_o = frame_height_q;
    assign frame_done_o   = frame_done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_cmos_decode_v2.sv
// Directed testbench for cmos_decode_v2 (DATA_W=8, BYTES_PER_PIX=2,
// FRAME_WAITCNT=2, VSYNC_POL=1). Inputs are driven on the falling edge,
// outputs are observed on the falling edge.
module tb_cmos_decode_v2;

  localparam int DATA_W = 8;
  localparam int BPP    = 2;
  localparam int PIX_W  = 16;
  localparam int CNT_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              href;
  logic              vsync;
  logic [DATA_W-1:0] data;
  logic              cap_en;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid, pix_sof, pix_eol, frame_done, err;
  logic [CNT_W-1:0]  frame_width, frame_height;

  cmos_decode_v2 #(
    .DATA_W(DATA_W), .BYTES_PER_PIX(BPP), .FRAME_WAITCNT(2), .VSYNC_POL(1), .CNT_W(CNT_W)
  ) dut (
    .cmos_pclk_i(clk), .rst_i(rst), .cmos_href_i(href), .cmos_vsync_i(vsync),
    .cmos_data_i(data), .capture_en_i(cap_en), .pix_data_o(pix_data),
    .pix_valid_o(pix_valid), .pix_sof_o(pix_sof), .pix_eol_o(pix_eol),
    .frame_width_o(frame_width), .frame_height_o(frame_height),
    .frame_done_o(frame_done), .err_o(err)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observed stream, captured on the falling edge.
  logic [PIX_W-1:0] obs_data_q[$];
  logic             obs_sof_q[$];
  logic             obs_eol_q[$];
  logic [PIX_W-1:0] exp_q[$];
  int err_cnt, done_cnt, last_eol_cyc, last_beat_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid) begin
        obs_data_q.push_back(pix_data);
        obs_sof_q.push_back(pix_sof);
        obs_eol_q.push_back(pix_eol);
        if (pix_eol) last_eol_cyc = cyc;
      end
      if (err) err_cnt++;
      if (frame_done) done_cnt++;
    end
  end

  // Driver tasks.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_data_q.delete();
    obs_sof_q.delete();
    obs_eol_q.delete();
    exp_q.delete();
    err_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic begin_frame();
    @(negedge clk);
    vsync = 1'b1;
    idle(4);
    vsync = 1'b0;
    idle(4);
  endtask

  task automatic end_frame();
    @(negedge clk);
    vsync = 1'b1;
    idle(6);
  endtask

  task automatic send_line(input int nbeats, input logic [7:0] base);
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = base + 8'(i);
      if (i == nbeats - 1) last_beat_cyc = cyc + 1;
    end
    @(negedge clk);
    href = 1'b0;
    data = '0;
  endtask

  // Expected pixels of a line built from beats base, base+1, ...
  task automatic push_exp(input int npix, input logic [7:0] base);
    for (int p = 0; p < npix; p++) begin
      logic [7:0] b0, b1;
      b0 = base + 8'(2 * p);
      b1 = base + 8'(2 * p + 1);
      exp_q.push_back({b0, b1});
    end
  endtask

  // Tests.
  task automatic test_reset();
    rst = 1'b1; href = 1'b0; vsync = 1'b0; data = '0; cap_en = 1'b1;
    idle(3);
    checks++;
    if ({pix_valid, pix_sof, pix_eol, frame_done, err, pix_data, frame_width, frame_height} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b sof=%b eol=%b done=%b err=%b data=%h w=%0d h=%0d, want all 0",
               pix_valid, pix_sof, pix_eol, frame_done, err, pix_data, frame_width, frame_height);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_skip_and_frame();
    clear_obs();
    for (int f = 0; f < 2; f++) begin
      begin_frame();
      for (int l = 0; l < 4; l++) begin send_line(16, 8'(l * 16)); idle(3); end
      end_frame();
    end
    checks++;
    if (obs_data_q.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL skip_frames: got %0d pixels %0d done, want 0 and 0", obs_data_q.size(), done_cnt);
    end
    clear_obs();
    begin_frame();
    for (int l = 0; l < 4; l++) begin send_line(16, 8'(l * 16)); push_exp(8, 8'(l * 16)); idle(3); end
    end_frame();
    checks++;
    if (obs_data_q.size() != 32) begin
      errors++;
      $display("FAIL frame_pix_count: got %0d, want 32", obs_data_q.size());
    end
    for (int i = 0; i < 32 && i < obs_data_q.size(); i++) begin
      checks++;
      if (obs_data_q[i] !== exp_q[i] || obs_sof_q[i] !== (i == 0) || obs_eol_q[i] !== (i % 8 == 7)) begin
        errors++;
        $display("FAIL frame_pix[%0d]: got data=%h sof=%b eol=%b, want data=%h sof=%b eol=%b",
                 i, obs_data_q[i], obs_sof_q[i], obs_eol_q[i], exp_q[i], (i == 0), (i % 8 == 7));
      end
    end
    checks++;
    if (last_eol_cyc - last_beat_cyc != 2) begin
      errors++;
      $display("FAIL eol_latency: got %0d cycles, want 2", last_eol_cyc - last_beat_cyc);
    end
    checks++;
    if (frame_width !== 12'd8 || frame_height !== 12'd4 || done_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL frame_status: got w=%0d h=%0d done=%0d err=%0d, want w=8 h=4 done=1 err=0",
               frame_width, frame_height, done_cnt, err_cnt);
    end
  endtask

  task automatic test_partial_pixel();
    clear_obs();
    begin_frame();
    send_line(16, 8'h00); push_exp(8, 8'h00); idle(3);
    send_line(7, 8'h40);  push_exp(3, 8'h40); idle(3);
    send_line(16, 8'h80); push_exp(8, 8'h80); idle(3);
    end_frame();
    checks++;
    if (obs_data_q.size() != 19) begin
      errors++;
      $display("FAIL partial_pix_count: got %0d, want 19", obs_data_q.size());
    end
    for (int i = 0; i < 19 && i < obs_data_q.size(); i++) begin
      checks++;
      if (obs_data_q[i] !== exp_q[i] || obs_eol_q[i] !== (i == 7 || i == 10 || i == 18)) begin
        errors++;
        $display("FAIL partial_pix[%0d]: got data=%h eol=%b, want data=%h eol=%b",
                 i, obs_data_q[i], obs_eol_q[i], exp_q[i], (i == 7 || i == 10 || i == 18));
      end
    end
    checks++;
    if (err_cnt != 1 || frame_width !== 12'd8 || frame_height !== 12'd3 || done_cnt != 1) begin
      errors++;
      $display("FAIL partial_status: got err=%0d w=%0d h=%0d done=%0d, want err=1 w=8 h=3 done=1",
               err_cnt, frame_width, frame_height, done_cnt);
    end
  endtask

  task automatic test_capture_en();
    clear_obs();
    cap_en = 1'b0;
    begin_frame();
    cap_en = 1'b1;
    for (int l = 0; l < 2; l++) begin send_line(8, 8'h10); idle(3); end
    end_frame();
    checks++;
    if (obs_data_q.size() != 0 || done_cnt != 0 || frame_width !== 12'd8 || frame_height !== 12'd3) begin
      errors++;
      $display("FAIL capture_off: got %0d pixels done=%0d w=%0d h=%0d, want 0 0 8 3",
               obs_data_q.size(), done_cnt, frame_width, frame_height);
    end
    clear_obs();
    begin_frame();
    for (int l = 0; l < 2; l++) begin send_line(8, 8'h20); idle(3); end
    end_frame();
    checks++;
    if (obs_data_q.size() != 8 || obs_sof_q[0] !== 1'b1 || obs_sof_q[1] !== 1'b0 ||
        done_cnt != 1 || frame_width !== 12'd4 || frame_height !== 12'd2) begin
      errors++;
      $display("FAIL capture_on: got %0d pixels sof0=%b done=%0d w=%0d h=%0d, want 8 1 1 4 2",
               obs_data_q.size(), obs_sof_q[0], done_cnt, frame_width, frame_height);
    end
  endtask

  task automatic test_blank_mid_line();
    clear_obs();
    begin_frame();
    send_line(16, 8'h00); idle(3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = 8'(i);
      if (i == 10) vsync = 1'b1;
    end
    @(negedge clk);
    href = 1'b0;
    idle(6);
    checks++;
    if (obs_data_q.size() != 12 || err_cnt != 1 || done_cnt != 1 ||
        frame_height !== 12'd1 || frame_width !== 12'd8) begin
      errors++;
      $display("FAIL blank_mid_line: got %0d pixels err=%0d done=%0d w=%0d h=%0d, want 12 1 1 8 1",
               obs_data_q.size(), err_cnt, done_cnt, frame_width, frame_height);
    end
  endtask

  task automatic test_reset_mid_line();
    clear_obs();
    begin_frame();
    for (int i = 0; i < 5; i++) begin @(negedge clk); href = 1'b1; data = 8'(i); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({pix_valid, pix_sof, pix_eol, frame_done, err, pix_data, frame_width, frame_height} !== '0) begin
      errors++;
      $display("FAIL reset_mid_line: got valid=%b w=%0d h=%0d data=%h, want all 0",
               pix_valid, frame_width, frame_height, pix_data);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    href = 1'b0;
    end_frame();
    clear_obs();
    for (int f = 0; f < 2; f++) begin begin_frame(); send_line(4, 8'h30); idle(3); end_frame(); end
    checks++;
    if (obs_data_q.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL reskip: got %0d pixels done=%0d, want 0 0", obs_data_q.size(), done_cnt);
    end
    begin_frame(); send_line(4, 8'h30); idle(3); end_frame();
    checks++;
    if (obs_data_q.size() != 2 || obs_sof_q[0] !== 1'b1 || done_cnt != 1 ||
        frame_width !== 12'd2 || frame_height !== 12'd1) begin
      errors++;
      $display("FAIL after_reskip: got %0d pixels sof0=%b done=%0d w=%0d h=%0d, want 2 1 1 2 1",
               obs_data_q.size(), obs_sof_q[0], done_cnt, frame_width, frame_height);
    end
  endtask

  task automatic test_line_check();
    int widths[4] = '{8, 8, 6, 8};
    clear_obs();
    begin_frame();
    for (int l = 0; l < 4; l++) begin send_line(2 * widths[l], 8'h00); idle(3); end
    end_frame();
`ifdef CMOS_DECODE_LINECHK_EN
    checks++;
    if (obs_data_q.size() != 30 || err_cnt != 1 || done_cnt != 0 ||
        frame_width !== 12'd2 || frame_height !== 12'd1) begin
      errors++;
      $display("FAIL line_check: got %0d pixels err=%0d done=%0d w=%0d h=%0d, want 30 1 0 2 1",
               obs_data_q.size(), err_cnt, done_cnt, frame_width, frame_height);
    end
`else
    checks++;
    if (obs_data_q.size() != 30 || err_cnt != 0 || done_cnt != 1 ||
        frame_width !== 12'd8 || frame_height !== 12'd4) begin
      errors++;
      $display("FAIL line_nocheck: got %0d pixels err=%0d done=%0d w=%0d h=%0d, want 30 0 1 8 4",
               obs_data_q.size(), err_cnt, done_cnt, frame_width, frame_height);
    end
`endif
  endtask

  initial begin
    err_cnt = 0; done_cnt = 0; last_eol_cyc = 0; last_beat_cyc = 0;
    test_reset();
    test_skip_and_frame();
    test_partial_pixel();
    test_capture_en();
    test_blank_mid_line();
    test_reset_mid_line();
    test_line_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
